arbitro_vc_param: RTL and testbench
===================================

// Module: arbitro_vc_param
// PURPOSE
// - Parametrised successor of the two-VC transmit-layer arbiter.
// - Selects one word per cycle from NUM_VC virtual-channel FIFOs (show-ahead) and routes it to one of NUM_DEST output FIFOs.
// - The destination is decoded from the word's upper bits. Honours per-destination pause (almost-full) backpressure.
// - Sits between the VC FIFOs and the destination FIFOs in the PCIe transmit path.
// PARAMETERS
// - DATA_W   6  word width
// - NUM_VC   2  number of input virtual channels (>=2)
// - NUM_DEST 2  number of output destinations (>=2)
// - DEST_W   1  destination field width = ceil(log2(NUM_DEST)), field is data[DATA_W-1 -: DEST_W]
// - CNT_W    8  width of drop counter
// PORTS
// - clk          in   1              rising-edge clock
// - reset_L      in   1              synchronous reset, active low
// - vc_data_i    in   NUM_VC*DATA_W  head word of each VC FIFO, VC i at [i*DATA_W +: DATA_W]
// - vc_empty_i   in   NUM_VC         FIFO empty flags
// - vc_pop_o     out  NUM_VC         pop strobe to VC FIFOs, one-hot or zero
// - dest_pause_i in   NUM_DEST       almost-full from destination FIFOs
// - dest_push_o  out  NUM_DEST       push strobe to destination FIFOs, one-hot or zero
// - dest_data_o  out  NUM_DEST*DATA_W  word per destination, dest d at [d*DATA_W +: DATA_W]
// - drop_cnt_o   out  CNT_W          count of words discarded for out-of-range destination
// - idle_o       out  1              all VCs empty and no push in flight
// BEHAVIOUR
// - Reset: synchronous, active-low, sampled on clk rise. While reset_L=0:
//   - vc_pop_o=0, dest_push_o=0, dest_data_o=0, drop_cnt_o=0, idle_o=1, RR pointer=0.
//   - Reset asserted mid-transfer discards the registered push.
// - Eligibility per cycle: VC i eligible iff !vc_empty_i[i] and (dest(i)>=NUM_DEST or !dest_pause_i[dest(i)]).
//   - Out-of-range words are always eligible, so they are flushed.
// - Grant: fixed priority, lowest eligible index wins.
// - vc_pop_o is combinational from the current inputs: same-cycle pop of the granted VC. Forced 0 when reset_L=0.
// - Latency 1: the word popped at cycle N appears at cycle N+1.
//   - dest_push_o[dest]=1 for exactly one cycle.
//   - dest_data_o[dest] holds the word; the other dest_data_o slices retain their last value.
// - Out-of-range dest: word is popped, no push, drop_cnt_o increments at N+1. Counter saturates at all-ones, no wrap.
// - Pause rising after a pop: the registered push still issues. Downstream almost-full threshold must absorb 1 word.
// - A paused high-priority VC never blocks a lower VC bound for an unpaused destination. No head-of-line blocking across VCs.
// - No grant when every non-empty VC targets a paused destination. Pops resume the cycle pause drops.
// - idle_o=1 iff vc_empty_i all 1 and no dest_push_o asserted this cycle.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined:
//   - Round-robin grant. Search starts at (last_grant+1) mod NUM_VC over eligible VCs.
//   - last_grant updates only on a grant and is held when there is no grant.
// - ARB_ROUND_ROBIN_EN undefined: fixed priority as above; no pointer register.
// TESTING
// - Reset: reset_L=0 for 2 cycles, vc_empty_i=2'b00 -> vc_pop_o=00, dest_push_o=00, drop_cnt_o=0, idle_o=1.
// - Priority: VC0=6'b110100, VC1=6'b010110, no pause, fixed mode
//   - cycle N: vc_pop_o=01.
//   - cycle N+1: dest_push_o=10, dest_data_o[1]=6'b110100.
// - Bypass: same data, dest_pause_i=2'b10
//   - VC1 popped (vc_pop_o=10).
//   - next cycle: dest_push_o=01, dest_data_o[0]=6'b010110; VC0 held.
// - Full stall: dest_pause_i=2'b11, both VCs non-empty -> vc_pop_o=00 and dest_push_o=00 every cycle.
//   - Release pause -> pop resumes the same cycle.
// - Round-robin (ARB_ROUND_ROBIN_EN): both VCs non-empty, no pause, 6 cycles -> grants 01,10,01,10,01,10.
// - Drop: NUM_DEST=3, DEST_W=2, DATA_W=6, word 6'b110001 (dest 3)
//   - popped, no push, drop_cnt_o 0->1.
//   - preload CNT_W=2 and drop 4 words -> holds at 2'b11.

Source files
------------

// File: rtl/arbitro_vc_param.sv
// Multi-VC to multi-destination transmit arbiter with per-destination pause backpressure.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin grant; fixed priority (lowest VC) otherwise.
module arbitro_vc_param #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned NUM_DEST = 2,
  parameter int unsigned DEST_W   = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [NUM_VC*DATA_W-1:0]     vc_data_i,
  input  logic [NUM_VC-1:0]            vc_empty_i,
  output logic [NUM_VC-1:0]            vc_pop_o,
  input  logic [NUM_DEST-1:0]          dest_pause_i,
  output logic [NUM_DEST-1:0]          dest_push_o,
  output logic [NUM_DEST*DATA_W-1:0]   dest_data_o,
  output logic [CNT_W-1:0]             drop_cnt_o,
  output logic                         idle_o
);

  localparam int unsigned VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned CMP_W = DEST_W + 1;

  logic [NUM_VC-1:0] eligible;
  logic              grant_valid;
  logic [VC_W-1:0]   grant_idx;
  logic [DATA_W-1:0] grant_word;
  logic [DEST_W-1:0] grant_dest;
  logic              grant_in_range;

`ifdef ARB_ROUND_ROBIN_EN
  logic [VC_W-1:0] rr_ptr;  // VC where the next search starts

  function automatic logic [VC_W-1:0] cand_of(input int unsigned k);
    return VC_W'((32'(rr_ptr) + k) % NUM_VC);
  endfunction
`else
  function automatic logic [VC_W-1:0] cand_of(input int unsigned k);
    return VC_W'(k);
  endfunction
`endif

  function automatic logic [DATA_W-1:0] word_of(input int unsigned i);
    return vc_data_i[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DEST_W-1:0] dest_of(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: DEST_W];
  endfunction

  function automatic logic in_range(input logic [DEST_W-1:0] d);
    return CMP_W'(d) < CMP_W'(NUM_DEST);
  endfunction

  function automatic logic is_paused(input logic [DEST_W-1:0] d);
    logic p;
    p = 1'b0;
    for (int unsigned dd = 0; dd < NUM_DEST; dd++)
      if (d == DEST_W'(dd)) p = dest_pause_i[dd];
    return p;
  endfunction

  // Out-of-range words are always eligible so they get flushed and counted.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_VC; i++)
      eligible[i] = !vc_empty_i[i] &&
                    (!in_range(dest_of(word_of(i))) || !is_paused(dest_of(word_of(i))));
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_word  = '0;
    for (int unsigned k = 0; k < NUM_VC; k++) begin
      if (!grant_valid && eligible[cand_of(k)]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_of(k);
        grant_word  = word_of(32'(cand_of(k)));
      end
    end
    grant_dest     = dest_of(grant_word);
    grant_in_range = in_range(grant_dest);
    vc_pop_o       = (reset_L && grant_valid) ? (NUM_VC'(1) << grant_idx) : '0;
  end

  assign idle_o = !reset_L || ((&vc_empty_i) && !(|dest_push_o));

  // Registered push stage; non-granted destination data slices hold their value.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      dest_push_o <= '0;
      dest_data_o <= '0;
      drop_cnt_o  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      dest_push_o <= '0;
      if (grant_valid) begin
        if (grant_in_range) begin
          for (int unsigned d = 0; d < NUM_DEST; d++) begin
            if (grant_dest == DEST_W'(d)) begin
              dest_push_o[d]                   <= 1'b1;
              dest_data_o[d*DATA_W +: DATA_W]  <= grant_word;
            end
          end
        end else if (drop_cnt_o != '1) begin
          drop_cnt_o <= drop_cnt_o + CNT_W'(1);
        end
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr <= VC_W'((32'(grant_idx) + 32'd1) % NUM_VC);
`endif
      end
    end
  end

endmodule

// File: tb/tb_arbitro_vc_param.sv
// Scoreboard bench for arbitro_vc_param: random traffic against a queue-based reference model,
// plus a second instance (3 destinations, 2-bit counter) for out-of-range drops and saturation.
module tb_arbitro_vc_param;
  localparam int unsigned DW = 6, NV = 2, ND = 2, DWD = 1, CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_L;
  logic [NV*DW-1:0] vc_data;
  logic [NV-1:0]    vc_empty;
  logic [NV-1:0]    vc_pop;
  logic [ND-1:0]    dest_pause;
  logic [ND-1:0]    dest_push;
  logic [ND*DW-1:0] dest_data;
  logic [CW-1:0]    drop_cnt;
  logic             idle;

  arbitro_vc_param #(.DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .DEST_W(DWD), .CNT_W(CW)) u_dut (
    .clk(clk), .reset_L(reset_L), .vc_data_i(vc_data), .vc_empty_i(vc_empty), .vc_pop_o(vc_pop),
    .dest_pause_i(dest_pause), .dest_push_o(dest_push), .dest_data_o(dest_data),
    .drop_cnt_o(drop_cnt), .idle_o(idle));

  logic        r_reset_L;
  logic [11:0] r_vc_data;
  logic [1:0]  r_vc_empty;
  logic [1:0]  r_vc_pop;
  logic [2:0]  r_dest_pause;
  logic [2:0]  r_dest_push;
  logic [17:0] r_dest_data;
  logic [1:0]  r_drop_cnt;
  logic        r_idle;

  arbitro_vc_param #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(3), .DEST_W(2), .CNT_W(2)) u_drop (
    .clk(clk), .reset_L(r_reset_L), .vc_data_i(r_vc_data), .vc_empty_i(r_vc_empty), .vc_pop_o(r_vc_pop),
    .dest_pause_i(r_dest_pause), .dest_push_o(r_dest_push), .dest_data_o(r_dest_data),
    .drop_cnt_o(r_drop_cnt), .idle_o(r_idle));

  typedef struct {
    logic [ND-1:0]    push;
    logic [ND*DW-1:0] data;
    logic [CW-1:0]    cnt;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference model state: what the outputs should show after the next clock edge.
  int unsigned m_data[ND];
  int unsigned m_cnt;
  int          m_push_dest;
  int          rr_next;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [NV-1:0] empty, input logic [NV*DW-1:0] data,
                                     input logic [ND-1:0] pause);
    int g;
    g = -1;
    for (int k = 0; k < NV; k++) begin
      int i, dst;
`ifdef ARB_ROUND_ROBIN_EN
      i = (rr_next + k) % NV;
`else
      i = k;
`endif
      dst = int'(data[i*DW +: DW]) >> (DW - DWD);
      if (g < 0 && !empty[i] && (dst >= ND || !pause[dst])) g = i;
    end
    return g;
  endfunction

  task automatic step(input logic rst_n, input logic [NV-1:0] empty, input logic [NV*DW-1:0] data,
                      input logic [ND-1:0] pause);
    int   g, dst;
    logic exp_idle;
    exp_t e;
    @(negedge clk);
    reset_L    = rst_n;
    vc_empty   = empty;
    vc_data    = data;
    dest_pause = pause;
    #1;
    g = rst_n ? model_grant(empty, data, pause) : -1;
    chk("vc_pop", 64'(vc_pop), (g >= 0) ? 64'(1) << g : 64'(0));
    exp_idle = !rst_n || ((empty == '1) && m_push_dest < 0);
    chk("idle", 64'(idle), 64'(exp_idle));
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) m_data[d] = 0;
      m_cnt = 0; m_push_dest = -1; rr_next = 0;
    end else if (g >= 0) begin
      dst = int'(data[g*DW +: DW]) >> (DW - DWD);
      if (dst < ND) begin
        m_push_dest = dst;
        m_data[dst] = int'(data[g*DW +: DW]);
      end else begin
        m_push_dest = -1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      rr_next = (g + 1) % NV;
    end else begin
      m_push_dest = -1;
    end
    e.push = (m_push_dest >= 0) ? ND'(1) << m_push_dest : '0;
    for (int d = 0; d < ND; d++) e.data[d*DW +: DW] = DW'(m_data[d]);
    e.cnt = CW'(m_cnt);
    sb.push_back(e);
  endtask

  // Monitor: each cycle after the edge, compare registered outputs to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dest_push", 64'(dest_push), 64'(e.push));
        chk("dest_data", 64'(dest_data), 64'(e.data));
        chk("drop_cnt", 64'(drop_cnt), 64'(e.cnt));
      end else if (dest_push !== '0) begin
        chk("unexpected_push", 64'(dest_push), 64'(0));
      end
    end
  end

  task automatic d3_cycle(input logic rst_n, input logic [1:0] empty, input logic [11:0] data,
                          input logic [2:0] pause, input logic [1:0] exp_pop,
                          input logic [2:0] exp_push, input logic [1:0] exp_cnt);
    @(negedge clk);
    r_reset_L = rst_n; r_vc_empty = empty; r_vc_data = data; r_dest_pause = pause;
    #1;
    chk("d3_vc_pop", 64'(r_vc_pop), 64'(exp_pop));
    @(posedge clk);
    #1;
    chk("d3_dest_push", 64'(r_dest_push), 64'(exp_push));
    chk("d3_drop_cnt", 64'(r_drop_cnt), 64'(exp_cnt));
  endtask

  initial begin
    logic [NV*DW-1:0] pri_data;
    m_cnt = 0; m_push_dest = -1; rr_next = 0;
    for (int d = 0; d < ND; d++) m_data[d] = 0;
    reset_L = 1'b0; vc_empty = '0; vc_data = '0; dest_pause = '0;
    r_reset_L = 1'b0; r_vc_empty = 2'b11; r_vc_data = '0; r_dest_pause = '0;

    pri_data = {6'b010110, 6'b110100};
    step(1'b0, 2'b00, pri_data, 2'b00);
    step(1'b0, 2'b00, pri_data, 2'b00);
    step(1'b1, 2'b00, pri_data, 2'b00);
    step(1'b1, 2'b00, pri_data, 2'b10);
    for (int c = 0; c < 3; c++) step(1'b1, 2'b00, pri_data, 2'b11);
    step(1'b1, 2'b00, pri_data, 2'b00);
    step(1'b1, 2'b11, pri_data, 2'b00);

    for (int c = 0; c < 3000; c++) begin
      logic [1:0] pz;
      pz = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step(($urandom_range(0, 63) != 0), 2'($urandom), 12'($urandom), pz);
    end
    step(1'b1, 2'b11, '0, 2'b00);
    step(1'b1, 2'b11, '0, 2'b00);
    @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb.size()), 64'(0));

    d3_cycle(1'b0, 2'b00, {6'b000000, 6'b110001}, 3'b000, 2'b00, 3'b000, 2'd0);
    d3_cycle(1'b0, 2'b00, {6'b000000, 6'b110001}, 3'b000, 2'b00, 3'b000, 2'd0);
    d3_cycle(1'b1, 2'b10, {6'b000000, 6'b110001}, 3'b000, 2'b01, 3'b000, 2'd1);
    d3_cycle(1'b1, 2'b10, {6'b000000, 6'b110001}, 3'b111, 2'b01, 3'b000, 2'd2);
    d3_cycle(1'b1, 2'b10, {6'b000000, 6'b110001}, 3'b000, 2'b01, 3'b000, 2'd3);
    d3_cycle(1'b1, 2'b10, {6'b000000, 6'b110001}, 3'b000, 2'b01, 3'b000, 2'd3);
    d3_cycle(1'b1, 2'b00, {6'b000011, 6'b100101}, 3'b100, 2'b10, 3'b001, 2'd3);
    chk("d3_data0", 64'(r_dest_data[5:0]), 64'(6'b000011));
    d3_cycle(1'b1, 2'b00, {6'b000011, 6'b100101}, 3'b000, 2'b01, 3'b100, 2'd3);
    chk("d3_data2", 64'(r_dest_data[17:12]), 64'(6'b100101));
    chk("d3_data0_hold", 64'(r_dest_data[5:0]), 64'(6'b000011));
    chk("d3_idle", 64'(r_idle), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
